dmem_port_arbiter: RTL and testbench

Arbitrates the single-port data SRAM between the CPU's operand-fetch reads and its write-back writes. It sits directly downstream of the CPU's memory stages and upstream of the data SRAM. Writes are posted into a small write buffer and drained when the SRAM port is idle. Reads take the port immediately and are forwarded from the buffer when they hit a pending write, which removes the read/write structural hazard on the data RAM.

---
 rtl/dmem_port_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Single-port data SRAM arbiter: reads take the port immediately, writes are posted
// into a circular buffer and drained on idle cycles, with read forwarding from pending writes.
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int WB_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  wb_empty,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  we_n
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(WB_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } port_state_e;

  port_state_e           state_r;
  port_state_e           state_next_s;

  logic [PW:0]           count_r;
  logic [PW:0]           count_next_s;
  logic [PW-1:0]         head_r;
  logic [PW-1:0]         tail_r;
  logic [ADDR_WIDTH-1:0] wb_addr_r [WB_DEPTH];
  logic [DATA_WIDTH-1:0] wb_data_r [WB_DEPTH];

  logic                  full_s;
  logic                  push_s;
  logic                  read_s;
  logic                  drain_s;

  logic [PW-1:0]         scan_idx_s;
  logic                  buf_hit_s;
  logic [DATA_WIDTH-1:0] buf_data_s;
  logic                  fwd_hit_s;
  logic [DATA_WIDTH-1:0] fwd_data_s;
  logic                  fwd_hit_r;
  logic [DATA_WIDTH-1:0] fwd_data_r;

  logic                  rd_valid_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic [ADDR_WIDTH-1:0] sram_addr_r;
  logic [DATA_WIDTH-1:0] sram_wdata_r;
  logic                  we_n_r;

  // Full blocks both requesters, so a full buffer always yields a drain cycle.
  assign full_s  = (count_r == FULL_CNT);
  assign push_s  = wr_req && !full_s;
  assign read_s  = rd_req && !full_s;
  assign drain_s = !read_s && (count_r != '0);

  assign rd_ready   = !full_s;
  assign wr_ready   = !full_s;
  assign wb_empty   = (count_r == '0) && we_n_r;
  assign rd_valid   = rd_valid_r;
  assign rd_data    = rd_data_r;
  assign sram_addr  = sram_addr_r;
  assign sram_wdata = sram_wdata_r;
  assign we_n       = we_n_r;

  // Port owner for the coming cycle.
  always_comb begin
    state_next_s = ST_IDLE;
    if (read_s) begin
      state_next_s = ST_READ;
    end else if (drain_s) begin
      state_next_s = ST_DRAIN;
    end else begin
      state_next_s = ST_IDLE;
    end
  end

  // Buffer occupancy after this edge; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, drain_s})
      2'b10:   count_next_s = count_r + (PW+1)'(1);
      2'b01:   count_next_s = count_r - (PW+1)'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    buf_hit_s  = 1'b0;
    buf_data_s = '0;
    scan_idx_s = head_r;
    for (int k = 0; k < WB_DEPTH; k++) begin
      scan_idx_s = head_r + PW'(k);
      if (((PW+1)'(k) < count_r) && (wb_addr_r[scan_idx_s] == rd_addr)) begin
        buf_hit_s  = 1'b1;
        buf_data_s = wb_data_r[scan_idx_s];
      end else begin
        buf_hit_s  = buf_hit_s;
        buf_data_s = buf_data_s;
      end
    end
  end

  // A same-cycle write is older in program order than the read, so it beats the buffer.
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = '0;
    if (push_s && (wr_addr == rd_addr)) begin
      fwd_hit_s  = 1'b1;
      fwd_data_s = wr_data;
    end else if (buf_hit_s) begin
      fwd_hit_s  = 1'b1;
      fwd_data_s = buf_data_s;
    end else begin
      fwd_hit_s  = 1'b0;
      fwd_data_s = '0;
    end
  end

  // Owner state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
      head_r  <= '0;
      tail_r  <= '0;
    end else begin
      count_r <= count_next_s;
      if (push_s) begin
        tail_r <= tail_r + PW'(1);
      end
      if (drain_s) begin
        head_r <= head_r + PW'(1);
      end
    end
  end

  // Buffer storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WB_DEPTH; i++) begin
        wb_addr_r[i] <= '0;
        wb_data_r[i] <= '0;
      end
    end else if (push_s) begin
      wb_addr_r[tail_r] <= wr_addr;
      wb_data_r[tail_r] <= wr_data;
    end
  end

  // SRAM port drive; address and write data hold on idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      sram_addr_r  <= '0;
      sram_wdata_r <= '0;
      we_n_r       <= 1'b1;
    end else begin
      case (state_next_s)
        ST_READ: begin
          sram_addr_r <= rd_addr;
          we_n_r      <= 1'b1;
        end
        ST_DRAIN: begin
          sram_addr_r  <= wb_addr_r[head_r];
          sram_wdata_r <= wb_data_r[head_r];
          we_n_r       <= 1'b0;
        end
        default: begin
          we_n_r <= 1'b1;
        end
      endcase
    end
  end

  // Forwarding decision is frozen at acceptance, then merged with SRAM data one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_hit_r  <= 1'b0;
      fwd_data_r <= '0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
    end else begin
      if (read_s) begin
        fwd_hit_r  <= fwd_hit_s;
        fwd_data_r <= fwd_data_s;
      end
      rd_valid_r <= (state_r == ST_READ);
      if (state_r == ST_READ) begin
        rd_data_r <= fwd_hit_r ? fwd_data_r : sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: stimulus pushes expected reads/writes into queues,
// a negedge monitor pops them whenever the DUT pulses rd_valid or drives we_n low.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic        rd_ready;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        wb_empty;
  logic [15:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
  logic        we_n;

  logic [15:0] mem [0:65535];
  logic [15:0] exp_rd [$];
  logic [31:0] exp_wr [$];

  int checks = 0;
  int errors = 0;

  dmem_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WB_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .wb_empty   (wb_empty),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .we_n       (we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: asynchronous read, write on rising edge while we_n is low.
  assign sram_rdata = mem[sram_addr];
  always @(posedge clk) begin
    if (!we_n) mem[sram_addr] <= sram_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output event must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_rd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_valid got data %h expected no read at %0t", rd_data, $time);
      end else begin
        chk("rd_data", {16'h0000, rd_data}, {16'h0000, exp_rd.pop_front()});
      end
    end
    if (!we_n) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sram_write got %h:%h expected none at %0t", sram_addr, sram_wdata, $time);
      end else begin
        chk("sram_write", {sram_addr, sram_wdata}, exp_wr.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] <= 16'h0000;
    reset   = 1'b1;
    rd_req  = 1'b0;
    rd_addr = 16'h0000;
    wr_req  = 1'b0;
    wr_addr = 16'h0000;
    wr_data = 16'h0000;
    tick(); tick();
    reset = 1'b0;
    repeat (5) tick();

    // Reset / idle state
    chk("rst_we_n",       {31'd0, we_n},     32'd1);
    chk("rst_rd_valid",   {31'd0, rd_valid}, 32'd0);
    chk("rst_wr_ready",   {31'd0, wr_ready}, 32'd1);
    chk("rst_rd_ready",   {31'd0, rd_ready}, 32'd1);
    chk("rst_wb_empty",   {31'd0, wb_empty}, 32'd1);
    chk("rst_sram_addr",  {16'd0, sram_addr},  32'h0000);
    chk("rst_sram_wdata", {16'd0, sram_wdata}, 32'h0000);
    chk("rst_rd_data",    {16'd0, rd_data},    32'h0000);

    // Single posted write drains one cycle after the push
    wr_req = 1'b1; wr_addr = 16'h0010; wr_data = 16'hBEEF;
    exp_wr.push_back({16'h0010, 16'hBEEF});
    tick();
    wr_req = 1'b0;
    chk("wr_push_we_n",    {31'd0, we_n},     32'd1);
    chk("wr_push_wb_empty",{31'd0, wb_empty}, 32'd0);
    tick();
    chk("drain_we_n",      {31'd0, we_n},      32'd0);
    chk("drain_addr",      {16'd0, sram_addr}, 32'h0010);
    chk("drain_wb_empty",  {31'd0, wb_empty},  32'd0);
    tick();
    chk("post_drain_we_n", {31'd0, we_n},     32'd1);
    chk("post_drain_empty",{31'd0, wb_empty}, 32'd1);
    chk("mem_0010",        {16'd0, mem[16'h0010]}, 32'hBEEF);

    // Plain read from SRAM
    mem[16'h0020] <= 16'h1234;
    rd_req = 1'b1; rd_addr = 16'h0020;
    exp_rd.push_back(16'h1234);
    tick();
    rd_req = 1'b0;
    chk("rd_lat_valid0", {31'd0, rd_valid},  32'd0);
    chk("rd_sram_addr",  {16'd0, sram_addr}, 32'h0020);
    tick();
    chk("rd_lat_valid1", {31'd0, rd_valid}, 32'd1);
    chk("rd_we_n",       {31'd0, we_n},     32'd1);
    tick();
    chk("rd_lat_valid2", {31'd0, rd_valid}, 32'd0);

    // Two writes to one address, then a read stream: youngest wins, no drain during reads
    wr_req = 1'b1; wr_addr = 16'h0030; wr_data = 16'h1111;
    exp_wr.push_back({16'h0030, 16'h1111});
    tick();
    wr_data = 16'h2222;
    exp_wr.push_back({16'h0030, 16'h2222});
    rd_req = 1'b1; rd_addr = 16'h0030;
    for (int i = 0; i < 6; i++) begin
      exp_rd.push_back(16'h2222);
      tick();
      wr_req = 1'b0;
      chk("stream_no_drain", {31'd0, we_n}, 32'd1);
    end
    rd_req = 1'b0;
    repeat (4) tick();
    chk("mem_0030", {16'd0, mem[16'h0030]}, 32'h2222);

    // Same-cycle read and write of one address
    rd_req = 1'b1; rd_addr = 16'h0040;
    wr_req = 1'b1; wr_addr = 16'h0040; wr_data = 16'h5A5A;
    exp_rd.push_back(16'h5A5A);
    exp_wr.push_back({16'h0040, 16'h5A5A});
    tick();
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (3) tick();
    rd_req = 1'b1;
    exp_rd.push_back(16'h5A5A);
    tick();
    rd_req = 1'b0;
    repeat (3) tick();

    // Fill the buffer under a held read request
    mem[16'h0100] <= 16'hCAFE;
    rd_req = 1'b1; rd_addr = 16'h0100;
    for (int i = 0; i < 4; i++) begin
      wr_req  = 1'b1;
      wr_addr = 16'h0200 + 16'(i);
      wr_data = 16'hA000 + 16'(i);
      exp_wr.push_back({16'h0200 + 16'(i), 16'hA000 + 16'(i)});
      exp_rd.push_back(16'hCAFE);
      tick();
    end
    wr_req = 1'b0;
    chk("full_rd_ready", {31'd0, rd_ready}, 32'd0);
    chk("full_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("full_wb_empty", {31'd0, wb_empty}, 32'd0);
    exp_rd.push_back(16'hCAFE);
    tick();
    chk("full_drain_we_n", {31'd0, we_n},      32'd0);
    chk("full_drain_addr", {16'd0, sram_addr}, 32'h0200);
    chk("full_rd_ready2",  {31'd0, rd_ready},  32'd1);
    chk("full_wr_ready2",  {31'd0, wr_ready},  32'd1);
    tick();
    rd_req = 1'b0;
    repeat (6) tick();
    chk("fill_done_empty", {31'd0, wb_empty}, 32'd1);
    chk("mem_0203", {16'd0, mem[16'h0203]}, 32'hA003);

    // Reset with two writes and one read still pending
    rd_req = 1'b1; rd_addr = 16'h0100;
    wr_req = 1'b1; wr_addr = 16'h0300; wr_data = 16'hB000;
    exp_rd.push_back(16'hCAFE);
    tick();
    wr_addr = 16'h0301; wr_data = 16'hB001;
    tick();
    rd_req = 1'b0; wr_req = 1'b0; reset = 1'b1;
    tick();
    chk("mid_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("mid_rst_we_n",     {31'd0, we_n},     32'd1);
    chk("mid_rst_wb_empty", {31'd0, wb_empty}, 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_we_n",     {31'd0, we_n},     32'd1);
      chk("post_rst_wb_empty", {31'd0, wb_empty}, 32'd1);
    end
    chk("post_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("mem_0300", {16'd0, mem[16'h0300]}, 32'h0000);
    chk("mem_0301", {16'd0, mem[16'h0301]}, 32'h0000);

    chk("rd_queue_drained", exp_rd.size(), 32'd0);
    chk("wr_queue_drained", exp_wr.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
